// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, ALU function type, immediate extension.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned IMM_W  = 16;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_ADDIU = 6'b001001,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110
  } opcode_t;

  typedef enum logic [5:0] {
    FN_JR   = 6'b001000,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110
  } funct_t;

  // ALU function codes share the R-type funct encodings.
  typedef funct_t alu_fn_t;

  // Logical immediates zero-extend; everything else sign-extends.
  function automatic logic [DATA_W-1:0] imm_ext(input logic [5:0] op, input logic [IMM_W-1:0] imm);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      return {{(DATA_W-IMM_W){1'b0}}, imm};
    else
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/gpr_file.sv
// 32x32 general-purpose register file: two combinational read ports, one write port.
// $0 is hardwired to zero. Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module gpr_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rs_val,
  output logic [DATA_W-1:0] o_rt_val,
  output logic [DATA_W-1:0] o_reg_v0
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_live;

  assign w_wr_live = i_wr_en && (i_wr_addr != '0);

  // Register array: asynchronous clear, writes to $0 dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '{default: '0};
    end else if (w_wr_live) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports; $0 forced to zero regardless of array contents.
  always_comb begin
    o_rs_val = '0;
    o_rt_val = '0;
    if (i_rs_addr != '0) o_rs_val = r_regs[i_rs_addr];
    if (i_rt_addr != '0) o_rt_val = r_regs[i_rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_live && (i_rs_addr == i_wr_addr)) o_rs_val = i_wr_data;
    if (w_wr_live && (i_rt_addr == i_wr_addr)) o_rt_val = i_wr_data;
`endif
  end

  assign o_reg_v0 = r_regs[2];

endmodule

// File: rtl/mips_exec_core.sv
// Execution core for the multi-cycle MIPS bus CPU: register file, ALU-control decode, 32-bit ALU.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module mips_exec_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic        alu_b_sel,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] alu_out,
  output logic [31:0] register_v0
);

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_alu_b;
  alu_fn_t           w_alu_fn;

  gpr_file u_gpr_file (
    .clk       (clk),
    .reset     (reset),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .i_wr_addr (wr_addr),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .o_rs_val  (w_rs_val),
    .o_rt_val  (w_rt_val),
    .o_reg_v0  (register_v0)
  );

  assign rs_val    = w_rs_val;
  assign rt_val    = w_rt_val;
  assign w_imm_ext = imm_ext(opcode, imm);
  assign w_alu_b   = alu_b_sel ? w_imm_ext : w_rt_val;

  // ALU control: R-type uses funct, logical immediates map to their op, all else adds.
  always_comb begin
    w_alu_fn = FN_ADDU;
    case (opcode)
      OP_RTYPE: w_alu_fn = alu_fn_t'(funct);
      OP_ADDIU: w_alu_fn = FN_ADDU;
      OP_ANDI:  w_alu_fn = FN_AND;
      OP_ORI:   w_alu_fn = FN_OR;
      OP_XORI:  w_alu_fn = FN_XOR;
      default:  w_alu_fn = FN_ADDU;
    endcase
  end

  // ALU datapath; unrecognised functions yield zero.
  always_comb begin
    alu_out = '0;
    case (w_alu_fn)
      FN_ADDU: alu_out = w_rs_val + w_alu_b;
      FN_SUBU: alu_out = w_rs_val - w_alu_b;
      FN_AND:  alu_out = w_rs_val & w_alu_b;
      FN_OR:   alu_out = w_rs_val | w_alu_b;
      FN_XOR:  alu_out = w_rs_val ^ w_alu_b;
      FN_JR:   alu_out = w_rs_val;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_exec_core.sv
// Scoreboard bench for mips_exec_core: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        alu_b_sel;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_out;
  logic [31:0] register_v0;

  mips_exec_core dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .imm         (imm),
    .alu_b_sel   (alu_b_sel),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_out     (alu_out),
    .register_v0 (register_v0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] v0;
  } exp_t;

  exp_t        sb_q[$];
  logic        chk = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl[32];
  string       cur_tag;

  // Architectural register read as seen in the current cycle.
  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mdl[a];
  endfunction

  // Reference ALU from the instruction-level rules.
  function automatic logic [31:0] mdl_alu(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] t,
                                          input logic [15:0] im, input logic bsel);
    logic [31:0] sx, zx, b;
    logic        logical;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    logical = (op == 6'd12) || (op == 6'd13) || (op == 6'd14);
    b = bsel ? (logical ? zx : sx) : t;
    if (op == 6'd12) return a & b;
    if (op == 6'd13) return a | b;
    if (op == 6'd14) return a ^ b;
    if (op != 6'd0)  return a + b;
    if (fn == 6'h21) return a + b;
    if (fn == 6'h23) return a - b;
    if (fn == 6'h24) return a & b;
    if (fn == 6'h25) return a | b;
    if (fn == 6'h26) return a ^ b;
    if (fn == 6'h08) return a;
    return 32'd0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  // Monitor: one pop per strobed cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got 0 entries required 1");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        cmp({e.tag, ".alu_out"}, alu_out, e.alu);
        cmp({e.tag, ".rs_val"}, rs_val, e.rs);
        cmp({e.tag, ".rt_val"}, rt_val, e.rt);
        cmp({e.tag, ".v0"}, register_v0, e.v0);
      end
    end
  end

  // Push expectation for the current inputs, then advance one clock and update the model.
  task automatic issue(input string tag);
    exp_t        e;
    logic [31:0] a, t;
    a = mdl_read(rs_addr);
    t = mdl_read(rt_addr);
    e.tag = tag;
    e.rs  = a;
    e.rt  = t;
    e.alu = mdl_alu(opcode, funct, a, t, imm, alu_b_sel);
    e.v0  = mdl[2];
    sb_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    chk = 1'b0;
    if (!reset && wr_en && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                        input logic bsel, input logic [4:0] ra, input logic [4:0] rb);
    opcode = op; funct = fn; imm = im; alu_b_sel = bsel; rs_addr = ra; rt_addr = rb;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en = en; wr_addr = a; wr_data = d;
  endtask

  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[8];
    ops = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd9, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h08, 6'h3F, 6'h00};
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    reset = 1'b1;
    set_op(6'd0, 6'h21, 16'd0, 1'b0, 5'd0, 5'd0);
    set_wr(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    issue("reset_hold");
    reset = 1'b0;

    // Preload operands.
    set_wr(1'b1, 5'd1, 32'hFFFFFFFF); issue("wr1");
    set_wr(1'b1, 5'd3, 32'h00000001); issue("wr3");
    set_wr(1'b1, 5'd4, 32'h00000010); issue("wr4");
    set_wr(1'b1, 5'd5, 32'hBFC00010); issue("wr5");

    // Write $2 while reading it in the same cycle, then read back.
    set_op(6'd0, 6'h21, 16'd0, 1'b0, 5'd2, 5'd2);
    set_wr(1'b1, 5'd2, 32'h12345678); issue("wr2_same_cycle");
    set_wr(1'b0, 5'd0, 32'd0);        issue("wr2_after");

    // $0 is immune to writes.
    set_op(6'd0, 6'h21, 16'd0, 1'b0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd0, 32'hDEADBEEF); issue("wr0");
    set_wr(1'b0, 5'd0, 32'd0);        issue("rd0");

    // R-type ops on $1/$3.
    set_op(6'd0, 6'h21, 16'd0, 1'b0, 5'd1, 5'd3); issue("addu");
    set_op(6'd0, 6'h23, 16'd0, 1'b0, 5'd3, 5'd1); issue("subu");
    set_op(6'd0, 6'h24, 16'd0, 1'b0, 5'd1, 5'd3); issue("and");
    set_op(6'd0, 6'h25, 16'd0, 1'b0, 5'd1, 5'd3); issue("or");
    set_op(6'd0, 6'h26, 16'd0, 1'b0, 5'd1, 5'd3); issue("xor");

    // Immediates with rs=0x10, imm=0xFFF0.
    set_op(6'd9,  6'h00, 16'hFFF0, 1'b1, 5'd4, 5'd0); issue("addiu");
    set_op(6'd13, 6'h00, 16'hFFF0, 1'b1, 5'd4, 5'd0); issue("ori");
    set_op(6'd12, 6'h00, 16'hFFF0, 1'b1, 5'd4, 5'd0); issue("andi");
    set_op(6'd14, 6'h00, 16'hFFF0, 1'b1, 5'd4, 5'd0); issue("xori");

    // JR pass-through and an undefined funct.
    set_op(6'd0, 6'h08, 16'd0, 1'b0, 5'd5, 5'd1); issue("jr");
    set_op(6'd0, 6'h3F, 16'd0, 1'b0, 5'd5, 5'd1); issue("bad_funct");

    // Asynchronous reset mid-cycle with nonzero contents.
    set_op(6'd0, 6'h21, 16'd0, 1'b0, 5'd2, 5'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    issue("reset_midcycle");
    reset = 1'b0;

    // Writeback loop: ADDIU $2,$2,5 three times.
    for (int k = 0; k < 3; k++) begin
      set_op(6'd9, 6'h00, 16'd5, 1'b1, 5'd2, 5'd0);
      set_wr(1'b1, 5'd2, mdl_alu(6'd9, 6'h00, mdl_read(5'd2), 32'd0, 16'd5, 1'b1));
      issue("accum");
    end
    set_wr(1'b0, 5'd0, 32'd0);
    issue("accum_final");

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      set_op(ops[$urandom_range(9)], ($urandom_range(7) == 0) ? 6'($urandom) : fns[$urandom_range(7)],
             16'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
      set_wr(1'($urandom), 5'($urandom_range(7)), $urandom);
      issue("rand");
    end

    set_wr(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
